// File: rtl/notconcat_sched_if.sv
// notconcat_sched_if
//   Request/result bundle for the notconcat scheduler.
//   master : requesters + result consumer (drives req_*, out_ready)
//   slave  : the scheduler (drives req_ready, out_*, busy)
//   req_valid/req_ready : per-requester handshake, req_ready one-hot or zero
//   req_data0/1         : 128-bit words from requester 0/1
//   out_valid/out_ready : result handshake
//   out_data/out_id     : assembled result and owning requester
//   busy                : transaction in flight (RUN or HOLD)
interface notconcat_sched_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_data0;
    logic [127:0] req_data1;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_id;
    logic         busy;

    modport master (
        output req_valid, req_data0, req_data1, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req_valid, req_data0, req_data1, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/notconcat_sched.sv
// notconcat_sched
//   Round-robin scheduler for two requesters sharing one 32-bit
//   byte-invert/pack lane ({~a,~b,~c,~d}). A granted 128-bit word is pushed
//   through the lane 32 bits per cycle (lane 0 first) and the assembled
//   128-bit result is held on the output handshake with the requester id.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : notconcat_sched_if.slave (request/result handshakes, busy)
// Optional build macro NOTCONCAT_SCHED_PERF_EN adds:
//   done_count     : 16-bit count of result handshakes (wraps)
//   conflict_count : 16-bit count of accepts with both requesters valid (wraps)
//
// state | meaning
// IDLE  | waiting for a request; req_ready driven from arbitration
// RUN   | one lane per cycle through the notconcat unit, lanes 0..3
// HOLD  | result valid, waiting for out_ready
module notconcat_sched (
    input  logic              clk,
    input  logic              rst,
    notconcat_sched_if.slave  bus
`ifdef NOTCONCAT_SCHED_PERF_EN
    ,
    output logic [15:0]       done_count,
    output logic [15:0]       conflict_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t       state_q, state_d;
    logic [1:0]   lane_q, lane_d;
    logic         rr_last_q, rr_last_d;
    logic [127:0] word_q, word_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         out_id_q, out_id_d;
    logic         busy_q, busy_d;

    logic [1:0]   grant;
    logic         accept;
    logic [31:0]  lane_in;
    logic [31:0]  lane_out;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        grant = 2'b00;
        case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE) ? grant : 2'b00;
    assign accept        = |bus.req_ready;

    // The single shared notconcat unit.
    assign lane_in  = word_q[{lane_q, 5'd0} +: 32];
    assign lane_out = {~lane_in[7:0], ~lane_in[15:8], ~lane_in[23:16], ~lane_in[31:24]};

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        rr_last_d   = rr_last_q;
        word_d      = word_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    word_d    = grant[1] ? bus.req_data1 : bus.req_data0;
                    out_id_d  = grant[1];
                    rr_last_d = grant[1];
                    lane_d    = 2'd0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                out_data_d[{lane_q, 5'd0} +: 32] = lane_out;
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lane_q      <= 2'd0;
            rr_last_q   <= 1'b1;
            word_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            rr_last_q   <= rr_last_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.busy      = busy_q;

`ifdef NOTCONCAT_SCHED_PERF_EN
    logic [15:0] done_count_q, done_count_d;
    logic [15:0] conflict_count_q, conflict_count_d;

    always_comb begin
        done_count_d     = done_count_q;
        conflict_count_d = conflict_count_q;
        if ((state_q == S_HOLD) && bus.out_ready)
            done_count_d = done_count_q + 16'd1;
        if (accept && (bus.req_valid == 2'b11))
            conflict_count_d = conflict_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_count_q     <= 16'd0;
            conflict_count_q <= 16'd0;
        end else begin
            done_count_q     <= done_count_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign done_count     = done_count_q;
    assign conflict_count = conflict_count_q;
`endif

endmodule

// File: tb/tb_notconcat_sched.sv
module tb_notconcat_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    notconcat_sched_if bus ();

`ifdef NOTCONCAT_SCHED_PERF_EN
    logic [15:0] done_count;
    logic [15:0] conflict_count;
    notconcat_sched dut (.clk(clk), .rst(rst), .bus(bus),
                         .done_count(done_count), .conflict_count(conflict_count));
`else
    notconcat_sched dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {
        logic         id;
        logic [127:0] data;
        int           vcyc;
    } exp_t;

    exp_t sb[$];
    int   acc_ids[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   model_busy = 1'b0;
    bit   release_pending = 1'b0;
    bit   rr_last_m = 1'b1;
    bit   accepted [2];
    int   done_m = 0;
    int   conflict_m = 0;

    // Reference: each 32-bit group has its bytes reversed and inverted.
    function automatic logic [127:0] ref_nc(input logic [127:0] w);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[((k / 4) * 4 + 3 - (k % 4)) * 8 +: 8] = ~w[k * 8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Arbitration model: what req_ready must be, and what gets accepted.
    task automatic check_and_accept();
        logic [1:0]   eg;
        logic [1:0]   er;
        logic         id;
        logic [127:0] w;
        case (bus.req_valid)
            2'b01:   eg = 2'b01;
            2'b10:   eg = 2'b10;
            2'b11:   eg = rr_last_m ? 2'b01 : 2'b10;
            default: eg = 2'b00;
        endcase
        er = model_busy ? 2'b00 : eg;
        chk("req_ready", 128'(bus.req_ready), 128'(er));
        chk("busy", 128'(bus.busy), 128'(model_busy));
        if (er != 2'b00) begin
            id = er[1];
            w  = id ? bus.req_data1 : bus.req_data0;
            sb.push_back('{id, ref_nc(w), cyc + 5});
            rr_last_m   = id;
            model_busy  = 1'b1;
            accepted[id] = 1'b1;
            acc_ids.push_back(int'(id));
            if (bus.req_valid == 2'b11) conflict_m++;
        end
        if (release_pending) begin
            model_busy      = 1'b0;
            release_pending = 1'b0;
        end
    endtask

    // One clock: model check before the edge, then drop accepted requests.
    task automatic tick();
        @(negedge clk);
        #2;
        if (!rst) check_and_accept();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (accepted[i]) begin
                bus.req_valid[i] = 1'b0;
                accepted[i]      = 1'b0;
            end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid", 128'(bus.out_valid), 128'(1));
    endtask

    // Monitor: pops the scoreboard on each result handshake.
    initial begin
        exp_t         e;
        logic         prev_v;
        logic [127:0] prev_d;
        logic         prev_id;
        prev_v  = 1'b0;
        prev_d  = '0;
        prev_id = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else if (bus.out_valid) begin
                if (!prev_v) begin
                    chk("sb_depth", 128'(sb.size()), 128'(1));
                    if (sb.size() > 0) chk("latency", 128'(cyc), 128'(sb[0].vcyc));
                end else begin
                    chk("hold_data", bus.out_data, prev_d);
                    chk("hold_id", 128'(bus.out_id), 128'(prev_id));
                end
                if (bus.out_ready) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("out_data", bus.out_data, e.data);
                        chk("out_id", 128'(bus.out_id), 128'(e.id));
                    end
                    release_pending = 1'b1;
                    done_m++;
                end
                prev_v  = !bus.out_ready;
                prev_d  = bus.out_data;
                prev_id = bus.out_id;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_data", bus.out_data, 128'(0));
        chk("rst_out_id", 128'(bus.out_id), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_req_ready", 128'(bus.req_ready), 128'(0));
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Known vector from requester 0.
        bus.req_data0 = {96'h0, 32'h04030201};
        bus.req_valid = 2'b01;
        wait_valid(20);
        chk("vec0_low", 128'(bus.out_data[31:0]), 128'(32'hFEFDFCFB));
        chk("vec0_high", 128'(bus.out_data[127:32]), 128'({96{1'b1}}));
        chk("vec0_id", 128'(bus.out_id), 128'(0));
        bus.out_ready = 1'b1;
        tick();

        // All-zero word from requester 1, consumer always ready.
        bus.req_data1 = '0;
        bus.req_valid = 2'b10;
        wait_valid(20);
        chk("zero_data", bus.out_data, {128{1'b1}});
        chk("zero_id", 128'(bus.out_id), 128'(1));
        tick();
        chk("pulse_len", 128'(bus.out_valid), 128'(0));

        // Back-pressure in HOLD with a request waiting.
        bus.out_ready = 1'b0;
        bus.req_data0 = rand128();
        bus.req_valid = 2'b01;
        wait_valid(20);
        bus.req_data1 = rand128();
        bus.req_valid = 2'b10;
        repeat (10) tick();
        chk("bp_valid", 128'(bus.out_valid), 128'(1));
        base = acc_ids.size();
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("accept_after_release", 128'(acc_ids.size()), 128'(base + 1));
        wait_valid(20);
        tick();

        // Reset while lane counter is at 2.
        bus.out_ready = 1'b0;
        bus.req_data0 = rand128();
        bus.req_valid = 2'b01;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", 128'(bus.busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_data", bus.out_data, 128'(0));
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        sb.delete();
        model_busy      = 1'b0;
        release_pending = 1'b0;
        rr_last_m       = 1'b1;
        done_m          = 0;
        conflict_m      = 0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Both requesters continuously valid: alternating grants from 0.
        bus.out_ready = 1'b1;
        base = acc_ids.size();
        for (int n = 0; n < 100 && acc_ids.size() < base + 4; n++) begin
            for (int i = 0; i < 2; i++)
                if (!bus.req_valid[i]) begin
                    bus.req_valid[i] = 1'b1;
                    if (i == 0) bus.req_data0 = rand128();
                    else        bus.req_data1 = rand128();
                end
            tick();
        end
        chk("tie_count", 128'(acc_ids.size()), 128'(base + 4));
        for (int k = 0; k < 4 && base + k < acc_ids.size(); k++)
            chk("grant_order", 128'(acc_ids[base + k]), 128'(k % 2));
        bus.req_valid = 2'b00;
        repeat (8) tick();
`ifdef NOTCONCAT_SCHED_PERF_EN
        chk("conflict_count4", 128'(conflict_count), 128'(4));
`endif

        // Randomized traffic with random back-pressure and request drops.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bus.req_valid[i] = 1'b1;
                        if (i == 0) bus.req_data0 = rand128();
                        else        bus.req_data1 = rand128();
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
        repeat (20) tick();
        chk("sb_drained", 128'(sb.size()), 128'(0));
        chk("idle_at_end", 128'(bus.busy), 128'(0));
`ifdef NOTCONCAT_SCHED_PERF_EN
        chk("done_count", 128'(done_count), 128'(done_m[15:0]));
        chk("conflict_count", 128'(conflict_count), 128'(conflict_m[15:0]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
